// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Brief   : Registered valid/ready ALU with N/Z/C/V flags and illegal-opcode
//           error. Define ALU_MUL_EN to build in the multi-cycle signed multiply.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [SIZEDATA-1:0] DATOA,
    input  logic [SIZEDATA-1:0] DATOB,
    input  logic [SIZEOP-1:0]   OPCODE,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [SIZEDATA-1:0] RESULT,
    output logic [3:0]          FLAGS,
    output logic                ERR
);

    localparam int MSB = SIZEDATA - 1;

    localparam logic [SIZEOP-1:0] OP_ADD  = SIZEOP'(6'b100000);
    localparam logic [SIZEOP-1:0] OP_SUB  = SIZEOP'(6'b100010);
    localparam logic [SIZEOP-1:0] OP_AND  = SIZEOP'(6'b100100);
    localparam logic [SIZEOP-1:0] OP_OR   = SIZEOP'(6'b100101);
    localparam logic [SIZEOP-1:0] OP_XOR  = SIZEOP'(6'b100110);
    localparam logic [SIZEOP-1:0] OP_NOR  = SIZEOP'(6'b100111);
    localparam logic [SIZEOP-1:0] OP_SRL  = SIZEOP'(6'b000010);
    localparam logic [SIZEOP-1:0] OP_SRA  = SIZEOP'(6'b000011);
    localparam logic [SIZEOP-1:0] OP_SLL  = SIZEOP'(6'b000000);
    localparam logic [SIZEOP-1:0] OP_SLT  = SIZEOP'(6'b101010);
    localparam logic [SIZEOP-1:0] OP_SLTU = SIZEOP'(6'b101011);
`ifdef ALU_MUL_EN
    localparam logic [SIZEOP-1:0] OP_MUL  = SIZEOP'(6'b011000);
`endif

    localparam logic [SIZEDATA-1:0] SHAMT_LIM = SIZEDATA[SIZEDATA-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                accept;
    logic                start_mul;
    logic [SIZEDATA-1:0] alu_res;
    logic                alu_c;
    logic                alu_v;
    logic                alu_err;
    logic [3:0]          alu_flags;
    logic [SIZEDATA:0]   sum;
    logic [SIZEDATA:0]   diff;

    assign IN_READY  = !RESET && ((state == IDLE) || ((state == HOLD) && OUT_READY));
    assign OUT_VALID = (state == HOLD);
    assign accept    = IN_VALID && IN_READY;

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_err   = 1'b0;
        start_mul = 1'b0;
        sum       = {1'b0, DATOA} + {1'b0, DATOB};
        diff      = {1'b0, DATOA} - {1'b0, DATOB};
        case (OPCODE)
            OP_ADD: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[SIZEDATA];
                alu_v   = (DATOA[MSB] == DATOB[MSB]) && (sum[MSB] != DATOA[MSB]);
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                alu_res = diff[MSB:0];
                alu_c   = diff[SIZEDATA];
                alu_v   = (DATOA[MSB] != DATOB[MSB]) && (diff[MSB] != DATOA[MSB]);
            end
            OP_AND:  alu_res = DATOA & DATOB;
            OP_OR:   alu_res = DATOA | DATOB;
            OP_XOR:  alu_res = DATOA ^ DATOB;
            OP_NOR:  alu_res = ~(DATOA | DATOB);
            OP_SLL:  alu_res = (DATOB >= SHAMT_LIM) ? '0 : (DATOA << DATOB);
            OP_SRL:  alu_res = (DATOB >= SHAMT_LIM) ? '0 : (DATOA >> DATOB);
            OP_SRA:  alu_res = (DATOB >= SHAMT_LIM) ? {SIZEDATA{DATOA[MSB]}}
                                                    : $unsigned($signed(DATOA) >>> DATOB);
            OP_SLT:  alu_res = {{(SIZEDATA-1){1'b0}}, ($signed(DATOA) < $signed(DATOB))};
            OP_SLTU: alu_res = {{(SIZEDATA-1){1'b0}}, (DATOA < DATOB)};
`ifdef ALU_MUL_EN
            OP_MUL:  start_mul = 1'b1;
`endif
            default: alu_err = 1'b1;
        endcase
        alu_flags = alu_err ? 4'b0100 : {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(SIZEDATA);

    logic [2*SIZEDATA-1:0] mcand;
    logic [SIZEDATA-1:0]   mplier;
    logic [2*SIZEDATA-1:0] acc;
    logic [2*SIZEDATA-1:0] acc_next;
    logic [CNT_W-1:0]      cnt;
    logic                  mul_last;
    logic                  mul_ovf;

    assign mul_last = (cnt == CNT_W'(SIZEDATA - 1));

    // Multiplier MSB carries weight -2^(N-1), so the final step subtracts.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = mul_last ? (acc - mcand) : (acc + mcand);
        end
        mul_ovf = !((acc_next[2*SIZEDATA-1:MSB] == '0) || (acc_next[2*SIZEDATA-1:MSB] == '1));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && start_mul) begin
            mcand  <= {{SIZEDATA{DATOA[MSB]}}, DATOA};
            mplier <= DATOB;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = start_mul ? BUSY : HOLD;
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (mul_last) begin
                    state_next = HOLD;
                end
            end
`endif
            HOLD: begin
                if (accept) begin
                    state_next = start_mul ? BUSY : HOLD;
                end else if (OUT_READY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESULT <= '0;
            FLAGS  <= 4'b0000;
            ERR    <= 1'b0;
        end else if (accept && !start_mul) begin
            RESULT <= alu_res;
            FLAGS  <= alu_flags;
            ERR    <= alu_err;
        end
`ifdef ALU_MUL_EN
        else if ((state == BUSY) && mul_last) begin
            RESULT <= acc_next[MSB:0];
            FLAGS  <= {acc_next[MSB], (acc_next[MSB:0] == '0), 1'b0, mul_ovf};
            ERR    <= 1'b0;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module  : tb_alu_seq
// Brief   : Self-checking bench for alu_seq: directed vectors, corner-case
//           sequences and randomized traffic against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_seq;

    localparam int W = 8;
    localparam int M = 1 << W;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;
    localparam logic [5:0] OP_MUL  = 6'b011000;

`ifdef ALU_MUL_EN
    localparam bit MUL_ON  = 1'b1;
    localparam int MUL_LAT = W + 1;
`else
    localparam bit MUL_ON  = 1'b0;
    localparam int MUL_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [5:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_retired = 0;

    always #5 clk = ~clk;

    alu_seq #(.SIZEDATA(W), .SIZEOP(6)) dut (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .DATOA(a), .DATOB(b), .OPCODE(op), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .RESULT(result), .FLAGS(flags), .ERR(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sval(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - M : int'(x);
    endfunction

    function automatic bit fits(input int x);
        return (x >= -(M / 2)) && (x <= (M / 2) - 1);
    endfunction

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic [5:0] mop, output logic [W-1:0] res,
                                  output logic [3:0] fl, output logic e);
        int full;
        logic c, v;
        full = 0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (mop)
            OP_ADD:  begin full = int'(ma) + int'(mb); c = (full >= M); v = !fits(sval(ma) + sval(mb)); end
            OP_SUB:  begin full = int'(ma) - int'(mb); c = (ma < mb);   v = !fits(sval(ma) - sval(mb)); end
            OP_AND:  full = int'(ma & mb);
            OP_OR:   full = int'(ma | mb);
            OP_XOR:  full = int'(ma ^ mb);
            OP_NOR:  full = int'(~(ma | mb));
            OP_SLL:  full = (int'(mb) >= W) ? 0 : (int'(ma) << mb);
            OP_SRL:  full = (int'(mb) >= W) ? 0 : (int'(ma) >> mb);
            OP_SRA:  full = (int'(mb) >= W) ? (ma[W-1] ? -1 : 0) : (sval(ma) >>> mb);
            OP_SLT:  full = (sval(ma) < sval(mb)) ? 1 : 0;
            OP_SLTU: full = (ma < mb) ? 1 : 0;
            OP_MUL:  begin
                if (MUL_ON) begin
                    full = sval(ma) * sval(mb);
                    v = !fits(full);
                end else begin
                    e = 1'b1;
                end
            end
            default: e = 1'b1;
        endcase
        res = e ? '0 : full[W-1:0];
        fl  = e ? 4'b0100 : {res[W-1], (res == '0), c, v};
    endfunction

    // Scoreboard: handshakes resolve at the next rising edge, inputs are stable here.
    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         e;
    } exp_t;
    exp_t         sb_q[$];
    exp_t         sb_x;
    logic [W-1:0] sb_r;
    logic [3:0]   sb_f;
    logic         sb_e;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_retired++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_output: got result 0x%0h with no pending request", result);
                end else begin
                    sb_x = sb_q.pop_front();
                    chk("sb_result", result, sb_x.res);
                    chk("sb_flags", flags, sb_x.fl);
                    chk("sb_err", err, sb_x.e);
                end
            end
            if (in_valid && in_ready) begin
                model(a, b, op, sb_r, sb_f, sb_e);
                sb_q.push_back('{sb_r, sb_f, sb_e});
            end
        end
    end

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [5:0]   vop;
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         e;
        int           lat;
    } vec_t;
    vec_t tbl[$];

    function automatic void add_vec(input string n, input logic [W-1:0] va, input logic [W-1:0] vb,
                                    input logic [5:0] vop, input logic [W-1:0] res,
                                    input logic [3:0] fl, input logic e, input int lat);
        vec_t v;
        v.name = n; v.va = va; v.vb = vb; v.vop = vop;
        v.res = res; v.fl = fl; v.e = e; v.lat = lat;
        tbl.push_back(v);
    endfunction

    task automatic do_op(input vec_t v);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({v.name, "_in_ready"}, in_ready, 1);
        a = v.va; b = v.vb; op = v.vop; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({v.name, "_latency"}, lat, v.lat);
        chk({v.name, "_result"}, result, v.res);
        chk({v.name, "_flags"}, flags, v.fl);
        chk({v.name, "_err"}, err, v.e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[12];
        logic [W-1:0] stream_exp[3];
        int n, pulses, ret0;

        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
                OP_SRL, OP_SRA, OP_SLL, OP_SLT, OP_SLTU, OP_MUL};

        add_vec("add_ovf",   8'h7F, 8'h01, OP_ADD,  8'h80, 4'b1001, 1'b0, 1);
        add_vec("add_carry", 8'hFF, 8'h01, OP_ADD,  8'h00, 4'b0110, 1'b0, 1);
        add_vec("sub_zero",  8'h05, 8'h05, OP_SUB,  8'h00, 4'b0100, 1'b0, 1);
        add_vec("sub_borrow",8'h03, 8'h05, OP_SUB,  8'hFE, 4'b1010, 1'b0, 1);
        add_vec("sra_3",     8'h80, 8'h03, OP_SRA,  8'hF0, 4'b1000, 1'b0, 1);
        add_vec("sra_9",     8'h80, 8'h09, OP_SRA,  8'hFF, 4'b1000, 1'b0, 1);
        add_vec("srl_9",     8'h80, 8'h09, OP_SRL,  8'h00, 4'b0100, 1'b0, 1);
        add_vec("sll_7",     8'h01, 8'h07, OP_SLL,  8'h80, 4'b1000, 1'b0, 1);
        add_vec("slt",       8'hFF, 8'h01, OP_SLT,  8'h01, 4'b0000, 1'b0, 1);
        add_vec("sltu",      8'hFF, 8'h01, OP_SLTU, 8'h00, 4'b0100, 1'b0, 1);
        add_vec("and",       8'hF0, 8'h3C, OP_AND,  8'h30, 4'b0000, 1'b0, 1);
        add_vec("or",        8'hF0, 8'h0F, OP_OR,   8'hFF, 4'b1000, 1'b0, 1);
        add_vec("xor",       8'hFF, 8'hFF, OP_XOR,  8'h00, 4'b0100, 1'b0, 1);
        add_vec("nor",       8'h00, 8'h00, OP_NOR,  8'hFF, 4'b1000, 1'b0, 1);
        add_vec("illegal",   8'h12, 8'h34, 6'h3F,   8'h00, 4'b0100, 1'b1, 1);
`ifdef ALU_MUL_EN
        add_vec("mul_neg",   8'hFD, 8'h04, OP_MUL,  8'hF4, 4'b1000, 1'b0, MUL_LAT);
        add_vec("mul_ovf",   8'h40, 8'h04, OP_MUL,  8'h00, 4'b0101, 1'b0, MUL_LAT);
`else
        add_vec("mul_off",   8'hFD, 8'h04, OP_MUL,  8'h00, 4'b0100, 1'b1, MUL_LAT);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        foreach (tbl[i]) do_op(tbl[i]);

        // Let the last table result retire before back-pressure.
        @(posedge clk); #1;

        a = 8'h10; b = 8'h20; op = OP_ADD; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 8'h30);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end

        stream_exp = '{8'h03, 8'hFE, 8'h00};
        ret0 = n_retired;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin a = 8'h01; b = 8'h02; end
                1: begin a = 8'h7F; b = 8'h7F; end
                default: begin a = 8'h80; b = 8'h80; end
            endcase
            op = OP_ADD; in_valid = 1'b1;
            #1;
            chk("stream_in_ready", in_ready, 1);
            @(posedge clk); #1;
            chk("stream_out_valid", out_valid, 1);
            chk("stream_result", result, stream_exp[i]);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_drained", out_valid, 0);
        chk("stream_retire_count", n_retired - ret0, 4);

        // Reset arriving on the fourth edge of a MUL.
        a = 8'hFD; b = 8'h04; op = OP_MUL; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("mulrst_in_ready_during", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mulrst_in_ready_after", in_ready, 1);
        chk("mulrst_out_valid", out_valid, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        chk("mulrst_no_pulse", pulses, 0);

        // Randomized traffic under random back-pressure.
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = W'($urandom);
            b = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 10)) : W'($urandom);
            op = ($urandom_range(0, 12) == 12) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        chk("final_pending", sb_q.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
